fmap_stream_sequencer: RTL and testbench

- Sequences one convolution layer: streams a zero-padded input feature map from the on-chip input buffer into the bank of 3x3 convolution featuremap blocks, one padded pixel per beat.
- Counts result beats to decide when a pass has drained.
- Repeats the stream once per output-featuremap group, then signals completion.
- Sits between the layer input buffer and the per-layer featuremap instances, under the top-level layer scheduler.

---
 rtl/fmap_seq_pkg.sv | 18 +
 rtl/fmap_skid_buffer.sv | 53 +++++
 rtl/fmap_stream_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_fmap_stream_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_seq_pkg.sv
// Shared types and geometry helpers for the feature-map stream sequencer.
package fmap_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STREAM = 3'd1,
      DRAIN  = 3'd2,
      NEXT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int unsigned PAD = 1;

   function automatic int unsigned padded_size(input int unsigned img);
      return img + 2 * PAD;
   endfunction

endpackage

// File: rtl/fmap_skid_buffer.sv
// Output register backed by a 2-entry skid store; the producer meters pushes
// with a credit count, so there is no upstream ready.
module fmap_skid_buffer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   output logic             dn_valid,
   output logic [WIDTH-1:0] dn_data,
   input  logic             dn_ready
);

   logic [WIDTH-1:0] ent0;
   logic [WIDTH-1:0] ent1;
   logic [1:0]       cnt;
   logic             load_c;

   // Output register may take a new beat when empty or being consumed.
   assign load_c = !dn_valid || dn_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dn_valid <= 1'b0;
         dn_data  <= '0;
         ent0     <= '0;
         ent1     <= '0;
         cnt      <= 2'd0;
      end else if (load_c) begin
         if (cnt == 2'd0) begin
            dn_valid <= up_valid;
            if (up_valid) dn_data <= up_data;
         end else begin
            dn_valid <= 1'b1;
            dn_data  <= ent0;
            if (cnt == 2'd1) begin
               if (up_valid) ent0 <= up_data;
               cnt <= up_valid ? 2'd1 : 2'd0;
            end else begin
               ent0 <= ent1;
               if (up_valid) ent1 <= up_data;
               cnt <= up_valid ? 2'd2 : 2'd1;
            end
         end
      end else if (up_valid) begin
         if (cnt == 2'd0) ent0 <= up_data;
         else             ent1 <= up_data;
         cnt <= cnt + 2'd1;
      end
   end

endmodule

// File: rtl/fmap_stream_sequencer.sv
// Streams a zero-padded input feature map to the conv bank once per output group.
// Optional macro FMAP_SEQ_PERF_CNT_EN adds the stall_cycles performance counter.
module fmap_stream_sequencer
   import fmap_seq_pkg::*;
#(
   parameter int unsigned IMG_SIZE      = 104,
   parameter int unsigned DATA_IN_WIDTH = 1024,
   parameter int unsigned ADDR_WIDTH    = 14,
   parameter int unsigned NUM_GROUPS    = 4
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(NUM_GROUPS):0]  group_idx,
   output logic                         rd_en,
   output logic [ADDR_WIDTH-1:0]        rd_addr,
   input  logic [DATA_IN_WIDTH-1:0]     rd_data,
   output logic [DATA_IN_WIDTH-1:0]     pix_data,
   output logic                         pix_valid,
   input  logic                         pix_ready,
   input  logic                         res_valid
`ifdef FMAP_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]                  stall_cycles
`endif
);

   localparam int unsigned PSZ     = padded_size(IMG_SIZE);
   localparam int unsigned PW      = $clog2(PSZ);
   localparam int unsigned NPIX    = IMG_SIZE * IMG_SIZE;
   localparam int unsigned RW      = 2 * ADDR_WIDTH;
   localparam int unsigned GW      = $clog2(NUM_GROUPS) + 1;
   localparam int unsigned CREDITS = 3;

   state_t                     state;
   logic [PW-1:0]              pr;
   logic [PW-1:0]              pc;
   logic [ADDR_WIDTH-1:0]      nxt_addr;
   logic                       all_issued;
   logic                       s1_vld;
   logic                       s1_zero;
   logic                       s2_vld;
   logic                       s2_zero;
   logic [1:0]                 outst;
   logic [RW-1:0]              rcnt;
   logic [DATA_IN_WIDTH-1:0]   push_data_c;

   logic accept_c;
   logic border_c;
   logic last_pos_c;
   logic credit_ok_c;
   logic issue_c;
   logic last_accept_c;

   always_comb begin
      accept_c      = pix_valid && pix_ready;
      border_c      = (pr == PW'(0)) || (pr == PW'(PSZ - 1)) ||
                      (pc == PW'(0)) || (pc == PW'(PSZ - 1));
      last_pos_c    = (pr == PW'(PSZ - 1)) && (pc == PW'(PSZ - 1));
      // Beats in flight (read pipe + skid + output reg) never exceed storage.
      credit_ok_c   = (outst != 2'(CREDITS)) || accept_c;
      issue_c       = (state == STREAM) && !all_issued && credit_ok_c;
      last_accept_c = (state == STREAM) && accept_c && all_issued && (outst == 2'd1);
      push_data_c   = s2_zero ? '0 : rd_data;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         group_idx  <= '0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         pr         <= '0;
         pc         <= '0;
         nxt_addr   <= '0;
         all_issued <= 1'b0;
         s1_vld     <= 1'b0;
         s1_zero    <= 1'b0;
         s2_vld     <= 1'b0;
         s2_zero    <= 1'b0;
         outst      <= 2'd0;
         rcnt       <= '0;
      end else begin
         rd_en   <= 1'b0;
         s1_vld  <= issue_c;
         s1_zero <= border_c;
         s2_vld  <= s1_vld;
         s2_zero <= s1_zero;
         outst   <= outst + 2'(issue_c) - 2'(accept_c);

         // Counters advance per issued beat; border beats skip the read.
         if (issue_c) begin
            if (!border_c) begin
               rd_en    <= 1'b1;
               rd_addr  <= nxt_addr;
               nxt_addr <= nxt_addr + ADDR_WIDTH'(1);
            end
            if (pc == PW'(PSZ - 1)) begin
               pc <= '0;
               pr <= pr + PW'(1);
            end else begin
               pc <= pc + PW'(1);
            end
            if (last_pos_c) all_issued <= 1'b1;
         end

         if (res_valid && (state == STREAM || state == DRAIN) && (rcnt != '1))
            rcnt <= rcnt + RW'(1);

         case (state)
            IDLE: begin
               if (start) begin
                  state      <= STREAM;
                  busy       <= 1'b1;
                  group_idx  <= '0;
                  pr         <= '0;
                  pc         <= '0;
                  nxt_addr   <= '0;
                  all_issued <= 1'b0;
               end
            end
            STREAM: begin
               if (last_accept_c) state <= DRAIN;
            end
            DRAIN: begin
               if (rcnt >= RW'(NPIX)) state <= NEXT;
            end
            NEXT: begin
               rcnt       <= '0;
               pr         <= '0;
               pc         <= '0;
               nxt_addr   <= '0;
               all_issued <= 1'b0;
               if (group_idx < GW'(NUM_GROUPS - 1)) begin
                  group_idx <= group_idx + GW'(1);
                  state     <= STREAM;
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   fmap_skid_buffer #(
      .WIDTH (DATA_IN_WIDTH)
   ) u_skid (
      .clk      (Clk),
      .rst_n    (Rst),
      .up_valid (s2_vld),
      .up_data  (push_data_c),
      .dn_valid (pix_valid),
      .dn_data  (pix_data),
      .dn_ready (pix_ready)
   );

`ifdef FMAP_SEQ_PERF_CNT_EN
   // Backpressure cycles seen during a layer; cleared by an accepted start.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         stall_cycles <= '0;
      end else if (state == IDLE && start) begin
         stall_cycles <= '0;
      end else if (busy && pix_valid && !pix_ready && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fmap_stream_sequencer.sv
// Directed self-checking bench: a 1-group and a 3-group sequencer on a 4x4 image.
module tb_fmap_stream_sequencer;

   localparam int unsigned IMG = 4;
   localparam int unsigned P   = IMG + 2;
   localparam int unsigned DW  = 1024;
   localparam int unsigned AW  = 4;

   logic          Clk;
   logic          Rst;
   logic          start;
   logic          pix_ready;
   logic          res_valid;
   logic          sel;
   logic          start1;
   logic          start3;

   logic          d1_busy, d1_done, d1_rd_en, d1_pix_valid;
   logic [0:0]    d1_gidx;
   logic [AW-1:0] d1_rd_addr;
   logic [DW-1:0] d1_pix_data, rd_data1;
   logic          d3_busy, d3_done, d3_rd_en, d3_pix_valid;
   logic [1:0]    d3_gidx;
   logic [AW-1:0] d3_rd_addr;
   logic [DW-1:0] d3_pix_data, rd_data3;
`ifdef FMAP_SEQ_PERF_CNT_EN
   logic [31:0]   d1_stall, d3_stall, m_stall;
`endif

   logic          m_valid, m_rd_en, m_done, m_busy;
   logic [DW-1:0] m_data;
   logic [AW-1:0] m_rd_addr;
   logic [1:0]    m_gidx;

   logic [DW-1:0] beats[$];
   int            beat_cyc[$];
   int            rd_addrs[$];
   int            done_cnt;
   int            stable_err;
   int            cyc;
   logic          prev_stall;
   logic [DW-1:0] prev_data;

   int            n_cmp;
   int            n_err;

   assign start1 = start && !sel;
   assign start3 = start && sel;

   fmap_stream_sequencer #(
      .IMG_SIZE(IMG), .DATA_IN_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_GROUPS(1)
   ) u_dut1 (
      .Clk(Clk), .Rst(Rst), .start(start1), .busy(d1_busy), .done(d1_done),
      .group_idx(d1_gidx), .rd_en(d1_rd_en), .rd_addr(d1_rd_addr), .rd_data(rd_data1),
      .pix_data(d1_pix_data), .pix_valid(d1_pix_valid), .pix_ready(pix_ready),
      .res_valid(res_valid)
`ifdef FMAP_SEQ_PERF_CNT_EN
      , .stall_cycles(d1_stall)
`endif
   );

   fmap_stream_sequencer #(
      .IMG_SIZE(IMG), .DATA_IN_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_GROUPS(3)
   ) u_dut3 (
      .Clk(Clk), .Rst(Rst), .start(start3), .busy(d3_busy), .done(d3_done),
      .group_idx(d3_gidx), .rd_en(d3_rd_en), .rd_addr(d3_rd_addr), .rd_data(rd_data3),
      .pix_data(d3_pix_data), .pix_valid(d3_pix_valid), .pix_ready(pix_ready),
      .res_valid(res_valid)
`ifdef FMAP_SEQ_PERF_CNT_EN
      , .stall_cycles(d3_stall)
`endif
   );

   always_comb begin
      m_valid   = sel ? d3_pix_valid : d1_pix_valid;
      m_data    = sel ? d3_pix_data  : d1_pix_data;
      m_rd_en   = sel ? d3_rd_en     : d1_rd_en;
      m_rd_addr = sel ? d3_rd_addr   : d1_rd_addr;
      m_done    = sel ? d3_done      : d1_done;
      m_busy    = sel ? d3_busy      : d1_busy;
      m_gidx    = sel ? d3_gidx      : {1'b0, d1_gidx};
`ifdef FMAP_SEQ_PERF_CNT_EN
      m_stall   = sel ? d3_stall     : d1_stall;
`endif
   end

   function automatic logic [DW-1:0] pat(input int a);
      logic [31:0] w;
      w = 32'hA500_0000 | 32'(a);
      return {32{w}};
   endfunction

   function automatic logic [DW-1:0] exp_beat(input int k);
      int r;
      int c;
      r = k / P;
      c = k % P;
      if (r == 0 || r == P - 1 || c == 0 || c == P - 1) return '0;
      return pat((r - 1) * IMG + (c - 1));
   endfunction

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Input buffer model: data valid the cycle after rd_en.
   always @(posedge Clk) begin
      if (d1_rd_en) rd_data1 <= pat(int'(d1_rd_addr));
      if (d3_rd_en) rd_data3 <= pat(int'(d3_rd_addr));
   end

   // Observe the selected instance mid-cycle.
   always @(negedge Clk) begin
      cyc <= cyc + 1;
      if (m_valid && pix_ready) begin
         beats.push_back(m_data);
         beat_cyc.push_back(cyc);
      end
      if (m_rd_en) rd_addrs.push_back(int'(m_rd_addr));
      if (m_done) done_cnt <= done_cnt + 1;
      if (Rst && prev_stall && (!m_valid || m_data !== prev_data))
         stable_err <= stable_err + 1;
      prev_stall <= Rst && m_valid && !pix_ready;
      prev_data  <= m_data;
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_beats(input int target, input int budget, input bit toggle, input string tag);
      int n;
      n = 0;
      while (beats.size() < target && n < budget) begin
         if (toggle) pix_ready = !pix_ready;
         tick();
         n++;
      end
      pix_ready = 1'b1;
      check({tag, "_beat_count"}, DW'(beats.size()), DW'(target));
   endtask

   task automatic check_pass(input int base, input string tag);
      for (int k = 0; k < P * P; k++)
         check($sformatf("%s_beat%0d", tag, k), beats[base + k], exp_beat(k));
   endtask

   task automatic res_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         res_valid = 1'b1;
         tick();
      end
      res_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n;
      n = 0;
      while (!m_done && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_done"}, DW'(m_done), DW'(1));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int b0;
      int r0;
      int dn0;
      int se0;

      n_cmp = 0; n_err = 0;
      done_cnt = 0; stable_err = 0; cyc = 0;
      prev_stall = 1'b0; prev_data = '0;
      rd_data1 = '0; rd_data3 = '0;
      Rst = 1'b0; start = 1'b0; pix_ready = 1'b1; res_valid = 1'b0; sel = 1'b0;

      // Reset state.
      repeat (3) tick();
      check("rst_busy",      DW'(d1_busy),      DW'(0));
      check("rst_done",      DW'(d1_done),      DW'(0));
      check("rst_gidx",      DW'(d1_gidx),      DW'(0));
      check("rst_rd_en",     DW'(d1_rd_en),     DW'(0));
      check("rst_rd_addr",   DW'(d1_rd_addr),   DW'(0));
      check("rst_pix_valid", DW'(d1_pix_valid), DW'(0));
      check("rst_pix_data",  d1_pix_data,       '0);
      check("rst_busy3",     DW'(d3_busy),      DW'(0));
      Rst = 1'b1;
      tick();

      // Single group, ready held high.
      b0 = beats.size(); r0 = rd_addrs.size(); dn0 = done_cnt;
      pulse_start();
      check("b_busy_after_start", DW'(m_busy), DW'(1));
      wait_beats(b0 + 36, 200, 1'b0, "b");
      check_pass(b0, "b");
      check("b_throughput", DW'(beat_cyc[b0 + 35] - beat_cyc[b0]), DW'(35));
      check("b_rd_count", DW'(rd_addrs.size() - r0), DW'(16));
      for (int k = 0; k < 16; k++)
         check($sformatf("b_rd_addr%0d", k), DW'(rd_addrs[r0 + k]), DW'(k));
      res_pulses(15);
      repeat (4) tick();
      check("b_no_early_done", DW'(done_cnt - dn0), DW'(0));
      check("b_busy_draining", DW'(m_busy), DW'(1));
      res_pulses(1);
      wait_done(20, "b");
      tick();
      check("b_busy_fall", DW'(m_busy), DW'(0));
      check("b_done_once", DW'(done_cnt - dn0), DW'(1));

      // Single group, ready toggling every cycle.
      b0 = beats.size(); r0 = rd_addrs.size(); dn0 = done_cnt; se0 = stable_err;
      pulse_start();
      wait_beats(b0 + 36, 300, 1'b1, "c");
      check_pass(b0, "c");
      check("c_stable", DW'(stable_err - se0), DW'(0));
      check("c_rd_count", DW'(rd_addrs.size() - r0), DW'(16));
      res_pulses(16);
      wait_done(20, "c");
      tick();
      check("c_no_extra_beats", DW'(beats.size() - b0), DW'(36));
      check("c_done_once", DW'(done_cnt - dn0), DW'(1));

      // Three groups.
      sel = 1'b1;
      tick();
      b0 = beats.size(); r0 = rd_addrs.size(); dn0 = done_cnt;
      pulse_start();
      for (int g = 0; g < 3; g++) begin
         wait_beats(b0 + 36 * (g + 1), 200, 1'b0, $sformatf("d_g%0d", g));
         check($sformatf("d_gidx%0d", g), DW'(m_gidx), DW'(g));
         check_pass(b0 + 36 * g, $sformatf("d_g%0d", g));
         res_pulses(16);
      end
      wait_done(20, "d");
      check("d_busy_in_done", DW'(m_busy), DW'(1));
      tick();
      check("d_busy_fall", DW'(m_busy), DW'(0));
      repeat (5) tick();
      check("d_rd_count", DW'(rd_addrs.size() - r0), DW'(48));
      for (int k = 0; k < 48; k += 5)
         check($sformatf("d_rd_addr%0d", k), DW'(rd_addrs[r0 + k]), DW'(k % 16));
      check("d_done_once", DW'(done_cnt - dn0), DW'(1));

      // Start in DRAIN and coincident with done are ignored.
      sel = 1'b0;
      tick();
      b0 = beats.size(); r0 = rd_addrs.size(); dn0 = done_cnt;
      pulse_start();
      wait_beats(b0 + 36, 200, 1'b0, "e");
      pulse_start();
      check("e_busy_after_drain_start", DW'(m_busy), DW'(1));
      check("e_gidx_drain", DW'(m_gidx), DW'(0));
      res_pulses(16);
      for (int i = 0; i < 20 && !m_done; i++) tick();
      check("e_done", DW'(m_done), DW'(1));
      pulse_start();
      check("e_busy_after_done", DW'(m_busy), DW'(0));
      repeat (6) tick();
      check("e_still_idle", DW'(m_busy), DW'(0));
      check("e_rd_count", DW'(rd_addrs.size() - r0), DW'(16));
      check("e_beats", DW'(beats.size() - b0), DW'(36));
      check("e_done_once", DW'(done_cnt - dn0), DW'(1));
      check("e_gidx", DW'(m_gidx), DW'(0));

      // Reset during STREAM at beat 10, then a clean pass.
      b0 = beats.size();
      pulse_start();
      wait_beats(b0 + 10, 100, 1'b0, "f_pre");
      Rst = 1'b0;
      #1;
      check("f_busy",      DW'(d1_busy),      DW'(0));
      check("f_done",      DW'(d1_done),      DW'(0));
      check("f_gidx",      DW'(d1_gidx),      DW'(0));
      check("f_rd_en",     DW'(d1_rd_en),     DW'(0));
      check("f_rd_addr",   DW'(d1_rd_addr),   DW'(0));
      check("f_pix_valid", DW'(d1_pix_valid), DW'(0));
      check("f_pix_data",  d1_pix_data,       '0);
      tick();
      Rst = 1'b1;
      tick();
      b0 = beats.size(); r0 = rd_addrs.size(); dn0 = done_cnt;
      pulse_start();
      wait_beats(b0 + 36, 200, 1'b0, "f");
      check_pass(b0, "f");
      check("f_first_addr", DW'(rd_addrs[r0]), DW'(0));
      res_pulses(16);
      wait_done(20, "f");
      tick();
      check("f_done_once", DW'(done_cnt - dn0), DW'(1));

`ifdef FMAP_SEQ_PERF_CNT_EN
      // Five stalled cycles with a beat pending.
      b0 = beats.size();
      pulse_start();
      for (int i = 0; i < 20 && !m_valid; i++) tick();
      check("g_valid_seen", DW'(m_valid), DW'(1));
      pix_ready = 1'b0;
      repeat (5) tick();
      pix_ready = 1'b1;
      wait_beats(b0 + 36, 200, 1'b0, "g");
      check_pass(b0, "g");
      res_pulses(16);
      wait_done(20, "g");
      check("g_stall_cycles", DW'(m_stall), DW'(5));
      repeat (3) tick();
      check("g_stall_hold", DW'(m_stall), DW'(5));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
